ir_svc: RTL and testbench



---
 rtl/ir_svc_pkg.sv | 27 ++
 rtl/ir_svc_evt_fifo.sv | 97 +++++++++
 rtl/ir_svc.sv | 103 ++++++++++
 tb/tb_ir_svc.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_svc_pkg.sv
// ir_pkg: shared types for the RTC alarm interrupt service unit.
// Holds the packed timestamp layout, its width and the service FSM states.
package ir_pkg;

  localparam int RTC_TIME_W = 44;

  // Captured timestamp, MSB to LSB exactly as presented on evt_data_o.
  typedef struct packed {
    logic [11:0] year;
    logic [3:0]  month;
    logic [4:0]  dom;
    logic [2:0]  dow;
    logic [1:0]  mode;
    logic [5:0]  hour;
    logic [5:0]  min;
    logic [5:0]  sec;
  } rtc_time_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    CAPT  = 3'd2,
    PUSH  = 3'd3,
    REARM = 3'd4
  } ir_svc_state_t;

endpackage

// File: rtl/ir_svc_evt_fifo.sv
// ir_evt_fifo: small circular event FIFO with a registered head.
// Handshake: an entry leaves when valid_o & ready_i are both high at a
// clock edge; push_i is a one-cycle write strobe with no back-pressure.
// Build option IR_SVC_OVERWRITE_EN: a push into a full FIFO without a pop
// replaces the oldest entry; otherwise that push is dropped. Either way the
// sticky overflow flag is set.
module ir_evt_fifo
  import ir_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = rtc_time_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  T              push_data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output T              data_o,
  output logic [CW-1:0] count_o,
  output logic          ovf_o,
  input  logic          ovf_clr_i
);

  T              mem_q [DEPTH];
  T              head_q, head_d;
  logic [AW:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, do_write, ovf_set;

  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop  = valid_q & ready_i;

  // Next pointers, overflow decision and the value the head register takes.
  always_comb begin
    rd_d     = rd_q;
    wr_d     = wr_q;
    do_write = 1'b0;
    ovf_set  = 1'b0;
    if (pop) rd_d = rd_q + 1'b1;
    if (push_i) begin
      if (!full || pop) begin
        do_write = 1'b1;
        wr_d     = wr_q + 1'b1;
      end else begin
        ovf_set = 1'b1;
`ifdef IR_SVC_OVERWRITE_EN
        do_write = 1'b1;
        wr_d     = wr_q + 1'b1;
        rd_d     = rd_q + 1'b1;
`endif
      end
    end
    // The head register always mirrors the slot at the new read pointer;
    // if that slot is being written this cycle, take the incoming data.
    head_d = head_q;
    if (do_write && (wr_q[AW-1:0] == rd_d[AW-1:0])) head_d = push_data_i;
    else if (rd_d != rd_q)                          head_d = mem_q[rd_d[AW-1:0]];
    count_d = CW'(wr_d - rd_d);
    valid_d = (wr_d != rd_d);
    ovf_d   = ovf_set ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk_i) begin
    if (do_write) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

  // Pointers, head, count and flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      head_q  <= T'('0);
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      head_q  <= head_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/ir_svc.sv
// ir_svc: services RTC alarm interrupts. A rising irq_i seen while idle
// produces a one-cycle ack_o; the timestamp the controller latches in
// response is captured and queued in ir_evt_fifo for the host.
// Host port: evt_data_o is consumed at a clock edge where evt_valid_o and
// evt_ready_i are both high.
// Build option IR_SVC_OVERWRITE_EN selects overwrite-oldest on overflow.
module ir_svc
  import ir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         irq_i,
  output logic                         ack_o,
  input  logic [5:0]                   snap_sec_i,
  input  logic [5:0]                   snap_min_i,
  input  logic [5:0]                   snap_hour_i,
  input  logic [1:0]                   snap_mode_i,
  input  logic [2:0]                   snap_dow_i,
  input  logic [4:0]                   snap_dom_i,
  input  logic [3:0]                   snap_month_i,
  input  logic [11:0]                  snap_year_i,
  output logic                         evt_valid_o,
  input  logic                         evt_ready_i,
  output logic [RTC_TIME_W-1:0]        evt_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   evt_count_o,
  output logic                         ovf_o,
  input  logic                         ovf_clr_i
);

  ir_svc_state_t state_q;
  logic          irq_q;
  logic          ack_q;
  rtc_time_t     capt_q;
  rtc_time_t     head;
  logic          push;

  // Previous irq_i level for edge detection; resets low so an irq_i already
  // high when reset is released still counts as a new edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= irq_i;
  end

  // Service sequence: acknowledge, capture, push, then wait for irq_i low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      capt_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (irq_i && !irq_q) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end
        end
        ACK: state_q <= CAPT;
        CAPT: begin
          capt_q.year  <= snap_year_i;
          capt_q.month <= snap_month_i;
          capt_q.dom   <= snap_dom_i;
          capt_q.dow   <= snap_dow_i;
          capt_q.mode  <= snap_mode_i;
          capt_q.hour  <= snap_hour_i;
          capt_q.min   <= snap_min_i;
          capt_q.sec   <= snap_sec_i;
          state_q      <= PUSH;
        end
        PUSH: state_q <= REARM;
        REARM: begin
          if (!irq_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push  = (state_q == PUSH);
  assign ack_o = ack_q;

  ir_evt_fifo #(
    .DEPTH (DEPTH),
    .T     (rtc_time_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (capt_q),
    .ready_i     (evt_ready_i),
    .valid_o     (evt_valid_o),
    .data_o      (head),
    .count_o     (evt_count_o),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  assign evt_data_o = head;

endmodule

// File: tb/tb_ir_svc.sv
// tb_ir_svc: directed and randomized checks of ir_svc against a timeline
// reference model (event queue + sticky overflow flag).
module tb_ir_svc;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, irq, ack, evt_valid, evt_ready, ovf, ovf_clr;
  logic [5:0]    snap_sec, snap_min, snap_hour;
  logic [1:0]    snap_mode;
  logic [2:0]    snap_dow;
  logic [4:0]    snap_dom;
  logic [3:0]    snap_month;
  logic [11:0]   snap_year;
  logic [43:0]   evt_data;
  logic [CW-1:0] evt_count;

  ir_svc #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .irq_i        (irq),
    .ack_o        (ack),
    .snap_sec_i   (snap_sec),
    .snap_min_i   (snap_min),
    .snap_hour_i  (snap_hour),
    .snap_mode_i  (snap_mode),
    .snap_dow_i   (snap_dow),
    .snap_dom_i   (snap_dom),
    .snap_month_i (snap_month),
    .snap_year_i  (snap_year),
    .evt_valid_o  (evt_valid),
    .evt_ready_i  (evt_ready),
    .evt_data_o   (evt_data),
    .evt_count_o  (evt_count),
    .ovf_o        (ovf),
    .ovf_clr_i    (ovf_clr)
  );

  // ---------------- reference model ----------------
  logic [43:0] exp_q[$];
  logic        m_ovf, m_ack, m_busy, m_prev_irq;
  logic [43:0] m_capt;
  int          cyc, m_edge;
  int          n_vec, n_err, ack_seen;

  function automatic logic [43:0] snap_now();
    return {snap_year, snap_month, snap_dom, snap_dow, snap_mode,
            snap_hour, snap_min, snap_sec};
  endfunction

  // Advance the model across one clock edge using the inputs now applied.
  // A service started by an edge in cycle E acks in E+1, captures the snap
  // present in E+2, queues it at the end of E+3 and is idle again after the
  // first cycle from E+4 on in which irq is low.
  task automatic model_step();
    logic pop, push, set;
    if (rst) begin
      exp_q.delete();
      m_ovf = 0; m_ack = 0; m_busy = 0; m_prev_irq = 0;
    end else begin
      pop  = (exp_q.size() > 0) && evt_ready;
      push = m_busy && (cyc == m_edge + 3);
      if (m_busy && (cyc == m_edge + 2)) m_capt = snap_now();
      set = 0;
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_capt);
        else begin
          set = 1;
`ifdef IR_SVC_OVERWRITE_EN
          void'(exp_q.pop_front());
          exp_q.push_back(m_capt);
`endif
        end
      end
      m_ovf = set ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      m_ack = 0;
      if (!m_busy && irq && !m_prev_irq) begin
        m_busy = 1; m_edge = cyc; m_ack = 1;
      end else if (m_busy && (cyc >= m_edge + 4) && !irq) begin
        m_busy = 0;
      end
      m_prev_irq = irq;
    end
    cyc++;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ack", 64'(ack), 64'(m_ack));
    chk("valid", 64'(evt_valid), 64'(exp_q.size() > 0));
    chk("count", 64'(evt_count), 64'(exp_q.size()));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    if (exp_q.size() > 0) chk("data", 64'(evt_data), 64'(exp_q[0]));
    if (ack === 1'b1) ack_seen++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic pulse(input int hi, input int lo);
    irq = 1;
    repeat (hi) tick();
    irq = 0;
    repeat (lo) tick();
  endtask

  task automatic set_snap(input logic [43:0] v);
    {snap_year, snap_month, snap_dom, snap_dow, snap_mode,
     snap_hour, snap_min, snap_sec} = v;
  endtask

  // ---------------- directed + random sequence ----------------
  logic [5:0]  exp_secs [4];
  logic [43:0] t2023;
  int          irq_hold;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; m_edge = 0; ack_seen = 0;
    m_capt = '0; m_ovf = 0; m_ack = 0; m_busy = 0; m_prev_irq = 0;
    rst = 1; irq = 0; evt_ready = 0; ovf_clr = 0;
    set_snap(44'h0);
    t2023 = {12'd2023, 4'd1, 5'd1, 3'd0, 2'd0, 6'd0, 6'd0, 6'd0};
`ifdef IR_SVC_OVERWRITE_EN
    exp_secs[0] = 6'd2; exp_secs[1] = 6'd3; exp_secs[2] = 6'd4; exp_secs[3] = 6'd5;
`else
    exp_secs[0] = 6'd1; exp_secs[1] = 6'd2; exp_secs[2] = 6'd3; exp_secs[3] = 6'd4;
`endif

    // Reset values, then a quiet irq line.
    repeat (3) tick();
    chk("rst_data", 64'(evt_data), 64'h0);
    rst = 0;
    ack_seen = 0;
    repeat (20) tick();
    chk("quiet_acks", 64'(ack_seen), 64'd0);

    // One long irq level: one ack one cycle later, entry visible 4 cycles later.
    set_snap(t2023);
    irq = 1;
    tick();
    chk("first_ack", 64'(ack), 64'd1);
    repeat (3) tick();
    chk("first_valid", 64'(evt_valid), 64'd1);
    chk("first_data", 64'(evt_data), 64'(t2023));
    chk("first_count", 64'(evt_count), 64'd1);
    repeat (46) tick();
    chk("long_level_acks", 64'(ack_seen), 64'd1);
    irq = 0;
    evt_ready = 1;
    repeat (3) tick();
    evt_ready = 0;

    // Five pulses into a depth-4 FIFO with no draining.
    for (int i = 1; i <= 5; i++) begin
      snap_sec = 6'(i);
      pulse(3, 3);
    end
    chk("five_count", 64'(evt_count), 64'(DEPTH));
    chk("five_ovf", 64'(ovf), 64'd1);
    evt_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(evt_valid), 64'd1);
      chk("drain_sec", 64'(evt_data[5:0]), 64'(exp_secs[i]));
      tick();
    end
    evt_ready = 0;
    chk("drained_empty", 64'(evt_valid), 64'd0);

    // Clear alone drops the flag the next cycle.
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    chk("clr_alone", 64'(ovf), 64'd0);

    // Full FIFO with a pop in the push cycle: nothing lost, no overflow.
    for (int i = 0; i < 4; i++) begin
      snap_sec = 6'(10 + i);
      pulse(3, 3);
    end
    snap_sec = 6'd14;
    irq = 1;
    repeat (3) tick();
    irq = 0;
    evt_ready = 1;
    tick();
    evt_ready = 0;
    repeat (2) tick();
    chk("full_pop_count", 64'(evt_count), 64'(DEPTH));
    chk("full_pop_ovf", 64'(ovf), 64'd0);
    chk("full_pop_head", 64'(evt_data[5:0]), 64'd11);
    evt_ready = 1;
    repeat (5) tick();
    evt_ready = 0;

    // Overflow push coincident with clear: set wins.
    for (int i = 0; i < 5; i++) begin
      snap_sec = 6'(20 + i);
      pulse(3, 3);
    end
    snap_sec = 6'd30;
    irq = 1;
    repeat (3) tick();
    irq = 0;
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    chk("clr_vs_set", 64'(ovf), 64'd1);
    repeat (2) tick();
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    chk("clr_after", 64'(ovf), 64'd0);
    evt_ready = 1;
    repeat (6) tick();
    evt_ready = 0;

    // Reset mid-service with irq still high across the release.
    snap_sec = 6'd40;
    pulse(3, 3);
    snap_sec = 6'd41;
    irq = 1;
    tick();
    chk("pre_rst_ack", 64'(ack), 64'd1);
    tick();
    rst = 1;
    repeat (2) tick();
    chk("rst_empty", 64'(evt_count), 64'd0);
    rst = 0;
    ack_seen = 0;
    tick();
    chk("post_rst_ack", 64'(ack), 64'd1);
    repeat (8) tick();
    chk("post_rst_acks", 64'(ack_seen), 64'd1);
    chk("post_rst_count", 64'(evt_count), 64'd1);
    irq = 0;
    evt_ready = 1;
    repeat (3) tick();

    // Randomized traffic: irq level runs, live snap values, host stalls.
    irq_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (irq_hold == 0) begin
        irq      = ~irq;
        irq_hold = $urandom_range(1, 8);
      end
      irq_hold--;
      set_snap({$urandom, $urandom});
      evt_ready = ($urandom_range(0, 3) == 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; irq = 0; ovf_clr = 0; evt_ready = 1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
